// File: rtl/skinny_masked_pkg.sv
// Shared types and constants for the masked Skinny-64 S-box blocks.
// Share pair type, gadget latency and golden S-box tables.
package skinny_masked_pkg;

  localparam int SBOX_HPC2_LAT = 2;

  typedef struct packed {
    logic [3:0] s0;
    logic [3:0] s1;
  } masked4_t;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } fsm_state_t;

  localparam logic [3:0] SBOX_FWD [16] = '{
    4'hc, 4'h6, 4'h9, 4'h0, 4'h1, 4'ha, 4'h2, 4'hb,
    4'h3, 4'h8, 4'h5, 4'hd, 4'h4, 4'he, 4'h7, 4'hf
  };

  localparam logic [3:0] SBOX_INV [16] = '{
    4'h3, 4'h4, 4'h6, 4'h8, 4'hc, 4'ha, 4'h1, 4'he,
    4'h9, 4'h2, 4'h5, 4'h7, 4'h0, 4'hb, 4'hd, 4'hf
  };

  function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
    return SBOX_FWD[x];
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    return SBOX_INV[x];
  endfunction

endpackage

// File: rtl/skinny_inv_sbox_core_d1.sv
// Masked inverse Skinny-64 S-box datapath, four NOR-XOR stages.
// Includes the first-order masking cells it is built from.
module not_masked (
  input  logic a_s0,
  input  logic a_s1,
  output logic b_s0,
  output logic b_s1
);
  assign b_s0 = ~a_s0;
  assign b_s1 = a_s1;
endmodule

module reg_masked #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic [W-1:0] d_s0,
  input  logic [W-1:0] d_s1,
  output logic [W-1:0] q_s0,
  output logic [W-1:0] q_s1
);
  // plain share-wise register stage
  always_ff @(posedge clk) begin
    q_s0 <= d_s0;
    q_s1 <= d_s1;
  end
endmodule

module and_HPC2 (
  input  logic clk,
  input  logic a_s0,
  input  logic a_s1,
  input  logic b_s0,
  input  logic b_s1,
  input  logic r,
  output logic c_s0,
  output logic c_s1
);
  logic a0_q, a1_q, ab0_q, ab1_q;
  logic u0_q, u1_q, r_q;
  logic [2:0] p0_q, p1_q;

  // first layer: local products, refreshed cross shares
  always_ff @(posedge clk) begin
    a0_q  <= a_s0;
    a1_q  <= a_s1;
    ab0_q <= a_s0 & b_s0;
    ab1_q <= a_s1 & b_s1;
    u0_q  <= b_s1 ^ r;
    u1_q  <= b_s0 ^ r;
    r_q   <= r;
  end

  // second layer: each partial term in its own register
  always_ff @(posedge clk) begin
    p0_q <= {ab0_q, ~a0_q & r_q, a0_q & u0_q};
    p1_q <= {ab1_q, ~a1_q & r_q, a1_q & u1_q};
  end

  assign c_s0 = ^p0_q;
  assign c_s1 = ^p1_q;
endmodule

module skinny_inv_sbox_core_d1 (
  input  logic       clk,
  input  logic [3:0] x_s0,
  input  logic [3:0] x_s1,
  input  logic [3:0] fresh,
  output logic [3:0] y_s0,
  output logic [3:0] y_s1
);
  logic [3:0] st_s0 [5];
  logic [3:0] st_s1 [5];

  assign st_s0[0] = x_s0;
  assign st_s1[0] = x_s1;

  for (genvar k = 0; k < 4; k++) begin : g_stage
    logic na_s0, na_s1, nb_s0, nb_s1;
    logic c_s0, c_s1;
    logic [3:0] d_s0, d_s1, q_s0, q_s1;
    logic [3:0] m_s0, m_s1;

    not_masked u_na (
      .a_s0(st_s0[k][3]), .a_s1(st_s1[k][3]),
      .b_s0(na_s0), .b_s1(na_s1)
    );
    not_masked u_nb (
      .a_s0(st_s0[k][2]), .a_s1(st_s1[k][2]),
      .b_s0(nb_s0), .b_s1(nb_s1)
    );
    and_HPC2 u_and (
      .clk(clk),
      .a_s0(na_s0), .a_s1(na_s1),
      .b_s0(nb_s0), .b_s1(nb_s1),
      .r(fresh[k]),
      .c_s0(c_s0), .c_s1(c_s1)
    );
    reg_masked #(.W(4)) u_d0 (
      .clk(clk),
      .d_s0(st_s0[k]), .d_s1(st_s1[k]),
      .q_s0(d_s0), .q_s1(d_s1)
    );
    reg_masked #(.W(4)) u_d1 (
      .clk(clk),
      .d_s0(d_s0), .d_s1(d_s1),
      .q_s0(q_s0), .q_s1(q_s1)
    );

    assign m_s0 = {q_s0[3:1], q_s0[0] ^ c_s0};
    assign m_s1 = {q_s1[3:1], q_s1[0] ^ c_s1};

    if (k < 3) begin : g_rot
      assign st_s0[k+1] = {m_s0[0], m_s0[3:1]};
      assign st_s1[k+1] = {m_s1[0], m_s1[3:1]};
    end else begin : g_last
      assign st_s0[k+1] = m_s0;
      assign st_s1[k+1] = m_s1;
    end
  end

  assign y_s0 = st_s0[4];
  assign y_s1 = st_s1[4];
endmodule

// File: rtl/skinny_inv_sbox_hpc2_d1.sv
// Masked inverse S-box with valid/ready front end.
// PIPELINED=1 streams, PIPELINED=0 holds one input at a time.
module skinny_inv_sbox_hpc2_d1
  import skinny_masked_pkg::*;
#(
  parameter int PIPELINED = 1,
  parameter int LATENCY   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] SI_s0,
  input  logic [3:0] SI_s1,
  input  logic [3:0] Fresh,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] SO_s0,
  output logic [3:0] SO_s1,
  output logic       out_valid,
  output logic       Synch
);
  logic [3:0] core_in_s0, core_in_s1;
  logic [3:0] core_out_s0, core_out_s1;

  if (LATENCY != 4 * SBOX_HPC2_LAT) begin : g_bad_lat
    $error("LATENCY must equal 4 HPC2 stages");
  end

  skinny_inv_sbox_core_d1 u_core (
    .clk(clk),
    .x_s0(core_in_s0), .x_s1(core_in_s1),
    .fresh(Fresh),
    .y_s0(core_out_s0), .y_s1(core_out_s1)
  );

  if (PIPELINED != 0) begin : g_pipe
    logic [LATENCY-1:0] vld;

    assign in_ready   = !rst;
    assign core_in_s0 = SI_s0;
    assign core_in_s1 = SI_s1;
    assign Synch      = 1'b0;

    // valid shift register follows data through the core
    always_ff @(posedge clk) begin
      if (rst) begin
        vld       <= '0;
        out_valid <= 1'b0;
        SO_s0     <= '0;
        SO_s1     <= '0;
      end else begin
        vld       <= {vld[LATENCY-2:0], in_valid && in_ready};
        out_valid <= vld[LATENCY-1];
        if (vld[LATENCY-1]) begin
          SO_s0 <= core_out_s0;
          SO_s1 <= core_out_s1;
        end
      end
    end
  end else begin : g_single
    localparam int CW = $clog2(LATENCY);
    fsm_state_t state;
    logic [CW-1:0] cnt;
    logic [3:0] hold_s0, hold_s1;

    assign in_ready   = !rst && (state == S_IDLE);
    assign core_in_s0 = (state == S_IDLE) ? SI_s0 : hold_s0;
    assign core_in_s1 = (state == S_IDLE) ? SI_s1 : hold_s1;

    // idle/busy sequencer with registered outputs
    always_ff @(posedge clk) begin
      if (rst) begin
        state     <= S_IDLE;
        cnt       <= '0;
        out_valid <= 1'b0;
        Synch     <= 1'b0;
        SO_s0     <= '0;
        SO_s1     <= '0;
      end else begin
        out_valid <= 1'b0;
        Synch     <= 1'b0;
        unique case (state)
          S_IDLE: begin
            if (in_valid) begin
              hold_s0 <= SI_s0;
              hold_s1 <= SI_s1;
              cnt     <= CW'(LATENCY - 1);
              state   <= S_BUSY;
            end
          end
          S_BUSY: begin
            if (cnt == '0) begin
              out_valid <= 1'b1;
              Synch     <= 1'b1;
              SO_s0     <= core_out_s0;
              SO_s1     <= core_out_s1;
              state     <= S_IDLE;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        endcase
      end
    end
  end
endmodule

// File: doc/skinny_inv_sbox_hpc2_d1.md
# skinny_inv_sbox_hpc2_d1

First-order masked inverse of the Skinny-64 4-bit S-box, built from `and_HPC2` gadgets, for the decryption datapath of the masked Skinny core. It inverts the forward masked S-box. It adds a valid/ready front end and a latency tracker so the surrounding round logic needs no external clock-gating controller. It operates in one of two modes, chosen at elaboration: fully pipelined, or single-shot with input hold.

## Interface
Parameters:
- `PIPELINED`, default 1: 1 = accepts one input per cycle; 0 = single-shot, busy until the result is out.
- `LATENCY`, default 8: fixed at 4 HPC2 stages × 2 cycles; any other value is an elaboration error.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `SI_s0`, `SI_s1` in 4 each: input shares; value = `SI_s0 ^ SI_s1`.
- `Fresh` in 4: one fresh random bit per HPC2 gadget; must be fresh every cycle.
- `in_valid` in 1: input shares valid.
- `in_ready` out 1: block accepts an input this cycle.
- `SO_s0`, `SO_s1` out 4 each: output shares.
- `out_valid` out 1: output shares valid; one-cycle pulse per accepted input.
- `Synch` out 1: in mode 0, high for the single cycle in which the block returns to IDLE; tied 0 in mode 1.

## Operation
- Function: `SO = S⁻¹(SI)`. The unmasked table for inputs 0..f is 3,4,6,8,c,a,1,e,9,2,5,7,0,b,d,f.
- Datapath: four serial NOR-XOR stages, each the reverse of one forward stage.
  - Each stage has exactly one `and_HPC2` on inverted shares, using `not_masked`, so that NOR = AND of NOTs.
  - Stage k uses `Fresh[k]`.
- Share bits not entering a stage's gadget are delayed by 2 registers so they stay aligned with the gadget output. This makes the datapath fully pipelined.
- Shares are never recombined; no register or gate mixes `s0` and `s1` outside the gadgets.
- Accept rule: an input is accepted when `in_valid && in_ready`.
- Mode 1: `in_ready` = `!rst`.
  - An 8-deep valid shift register tracks accepted inputs.
  - `out_valid` is its tail.
- Mode 0 FSM with states IDLE and BUSY:
  - IDLE: `in_ready=1`. On accept, capture the shares into the input hold register, load `cnt=LATENCY-1`, and go to BUSY.
  - BUSY: `in_ready=0`; the hold register drives the datapath, and `cnt` decrements each cycle.
  - When `cnt==0`: assert `out_valid`, register `SO`, pulse `Synch`, and return to IDLE.
  - `in_valid` is ignored while BUSY.
- Outputs `SO_s*` are registered.
  - They update only in a cycle with `out_valid=1`; otherwise they hold their last value.

## Timing
- Reset values, taking effect the cycle after `rst` is sampled high:
  - `out_valid=0`, `Synch=0`, `SO_s0=SO_s1=0`.
  - Valid pipeline cleared; FSM in IDLE with `cnt=0`.
  - `in_ready=0` while `rst=1`.
- Latency: an input accepted at edge t produces `out_valid` at edge t+8 in both modes.
- Mode 1 throughput: 1 result per cycle; back-to-back inputs give back-to-back `out_valid`.
- Mode 0: an input is accepted at most once every 9 cycles. In the `Synch` cycle the FSM is already in IDLE, so `in_ready=1` again.
- Reset mid-operation: all in-flight results are dropped, and no `out_valid` appears for inputs accepted before reset.
- `in_valid=1` during `rst=1` is not accepted.

## Structure
- Package `skinny_masked_pkg`:
  - `localparam SBOX_HPC2_LAT = 2`.
  - The forward and inverse S-box tables, used as bench golden functions.
  - The share-pair typedef `masked4_t` (two 4-bit shares).
- Sub-module `skinny_inv_sbox_core_d1`: the pure masked datapath, i.e. the 4 stages with gadgets and alignment registers, with no handshake. The top level adds the valid pipeline or the FSM and the output registers.
- Reuses the existing `and_HPC2`, `not_masked` and `reg_masked` cells.

## Test plan
- Mode 1, all 16 values × random masks over 1000 cycles with `in_valid=1` every cycle → `out_valid` continuous from cycle 8, and `SO_s0^SO_s1` matches the table in order (e.g. in 0xc → 0x0, in 0x0 → 0x3).
- Round trip: forward masked S-box feeding this block → recombined output equals the original input for all 16 values.
- Mode 0: `in_valid` held high → accepts at cycles 0, 9, 18; `Synch` and `out_valid` pulse at 8, 17, 26; `in_ready=0` in cycles 1–8.
- Reset asserted at cycle 4 after accepting 0x5 → no `out_valid`, `SO=0`, FSM in IDLE, next input accepted normally.
- Masking sanity: same input 0x7 with 100 random `SI_s0` values and `Fresh` values → recombined output always 0xe, while the individual `SO_s0` values are non-constant.
- `in_valid=1` with `rst=1` for 3 cycles → nothing accepted and no `out_valid` within the following 10 cycles.
